// File: rtl/isp_pkg.sv
// Shared ISP definitions: color codes, gain format defaults, AWB FSM encoding
// and the pixel record carried down the correction pipeline.
package isp_pkg;

   localparam logic [1:0] RED   = 2'd0;
   localparam logic [1:0] GREEN = 2'd1;
   localparam logic [1:0] BLUE  = 2'd2;

   localparam int GAIN_W_DEF    = 10;
   localparam int GAIN_FRAC_DEF = 6;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DIV_R  = 2'd1,
      DIV_B  = 2'd2,
      COMMIT = 2'd3
   } awb_state_t;

   typedef struct packed {
      logic [1:0] color;
      logic [7:0] value;
      logic       last;
   } pix_t;

endpackage

// File: rtl/awb_gain_if.sv
// Pixel stream, channel means and gain status bundle for awb_gain.
// Manual gain override signals exist only when AWB_MANUAL_EN is defined.
interface awb_gain_if #(
   parameter int GAIN_W = isp_pkg::GAIN_W_DEF
);
   logic              valid_i;
   logic [1:0]        color_i;
   logic [7:0]        value_i;
   logic              last_i;
   logic [7:0]        r_mean_i;
   logic [7:0]        g_mean_i;
   logic [7:0]        b_mean_i;
   logic              finish_i;
`ifdef AWB_MANUAL_EN
   logic              manual_i;
   logic [GAIN_W-1:0] manual_gain_r_i;
   logic [GAIN_W-1:0] manual_gain_b_i;
`endif
   logic              valid_o;
   logic [1:0]        color_o;
   logic [7:0]        value_o;
   logic              last_o;
   logic [GAIN_W-1:0] gain_r_o;
   logic [GAIN_W-1:0] gain_b_o;
   logic              gains_valid_o;
   logic              busy_o;
   logic              overrun_o;

   modport master (
      output valid_i, color_i, value_i, last_i,
      output r_mean_i, g_mean_i, b_mean_i, finish_i,
`ifdef AWB_MANUAL_EN
      output manual_i, manual_gain_r_i, manual_gain_b_i,
`endif
      input  valid_o, color_o, value_o, last_o,
      input  gain_r_o, gain_b_o, gains_valid_o, busy_o, overrun_o
   );

   modport slave (
      input  valid_i, color_i, value_i, last_i,
      input  r_mean_i, g_mean_i, b_mean_i, finish_i,
`ifdef AWB_MANUAL_EN
      input  manual_i, manual_gain_r_i, manual_gain_b_i,
`endif
      output valid_o, color_o, value_o, last_o,
      output gain_r_o, gain_b_o, gains_valid_o, busy_o, overrun_o
   );

endinterface

// File: rtl/awb_gain_div.sv
// Sequential restoring divider, one quotient bit per cycle MSB first.
// done is high during the final iteration; quotient is valid from the next cycle.
module awb_div #(
   parameter int QW     = 14,
   parameter int GAIN_W = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [QW-1:0]     dividend,
   input  logic [7:0]        divisor,
   output logic [GAIN_W-1:0] quotient,
   output logic              done
);
   localparam int CW = $clog2(QW + 1);

   // acc shifts dividend bits out of the top while quotient bits enter below
   logic [QW-1:0] acc;
   logic [7:0]    rem;
   logic [7:0]    dsr;
   logic [CW-1:0] cnt;
   logic          run;
   logic [8:0]    trial;

   assign trial = {rem, acc[QW-1]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
         rem <= '0;
         dsr <= '0;
         cnt <= '0;
         run <= 1'b0;
      end else if (start) begin
         acc <= dividend;
         rem <= '0;
         dsr <= divisor;
         cnt <= CW'(QW);
         run <= 1'b1;
      end else if (run) begin
         cnt <= cnt - 1'b1;
         if (cnt == CW'(1))
            run <= 1'b0;
         // zero divisor keeps the same cycle count but never touches acc
         if (dsr != 8'd0) begin
            if (trial >= {1'b0, dsr}) begin
               rem <= 8'(trial - {1'b0, dsr});
               acc <= {acc[QW-2:0], 1'b1};
            end else begin
               rem <= trial[7:0];
               acc <= {acc[QW-2:0], 1'b0};
            end
         end
      end
   end

   assign done     = run && (cnt == CW'(1));
   assign quotient = ((dsr == 8'd0) || (|acc[QW-1:GAIN_W])) ? {GAIN_W{1'b1}}
                                                            : acc[GAIN_W-1:0];

endmodule

// File: rtl/awb_gain.sv
// Gray-world white-balance gain stage: divides green mean by red/blue means and
// applies the committed gains to the pixel stream. Optional AWB_MANUAL_EN override.
module awb_gain
   import isp_pkg::*;
#(
   parameter int GAIN_W    = GAIN_W_DEF,
   parameter int GAIN_FRAC = GAIN_FRAC_DEF
) (
   input  logic      clk,
   input  logic      rst_n,
   awb_gain_if.slave bus
);
   localparam int QW = 8 + GAIN_FRAC;
   localparam int PW = 8 + GAIN_W;
   localparam logic [GAIN_W-1:0] UNITY = GAIN_W'(1 << GAIN_FRAC);
   localparam logic [PW:0]       HALF  = (PW+1)'(1 << (GAIN_FRAC-1));

   logic [GAIN_W-1:0] gain_r, gain_b, q_r;

   // ---------------- pixel path ----------------
   logic [1:0]        vld_pipe;
   pix_t              s1, s2;
   logic [GAIN_W-1:0] gain_sel;
   logic              bypass;
   logic [PW-1:0]     prod;
   logic [PW:0]       rnd, shf;
   logic [7:0]        val_sat;

   always_comb begin
      gain_sel = UNITY;
      bypass   = 1'b1;
      if (s1.color == RED) begin
         gain_sel = gain_r;
         bypass   = 1'b0;
      end else if (s1.color == BLUE) begin
         gain_sel = gain_b;
         bypass   = 1'b0;
      end
      prod    = PW'(s1.value) * PW'(gain_sel);
      rnd     = {1'b0, prod} + HALF;
      shf     = rnd >> GAIN_FRAC;
      val_sat = (|shf[PW:8]) ? 8'hFF : shf[7:0];
      if (bypass)
         val_sat = s1.value;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe <= '0;
         s1       <= '0;
         s2       <= '0;
      end else begin
         vld_pipe <= {vld_pipe[0], bus.valid_i};
         s1       <= '{color: bus.color_i, value: bus.value_i, last: bus.last_i};
         s2       <= '{color: s1.color, value: val_sat, last: s1.last};
      end
   end

   // ---------------- gain computation ----------------
   awb_state_t        state;
   logic [7:0]        m_g, m_b;
   logic              b_loaded, gains_valid, busy, overrun, man;
   logic              div_start, div_done;
   logic [QW-1:0]     div_dvd;
   logic [7:0]        div_dsr;
   logic [GAIN_W-1:0] div_q;

`ifdef AWB_MANUAL_EN
   assign man = bus.manual_i;
`else
   assign man = 1'b0;
`endif

   // red divide launches straight from the input means; blue from the latched copy
   assign div_start = !man && ((state == IDLE && bus.finish_i) || (state == DIV_B && !b_loaded));
   assign div_dvd   = (state == IDLE) ? {bus.g_mean_i, {GAIN_FRAC{1'b0}}} : {m_g, {GAIN_FRAC{1'b0}}};
   assign div_dsr   = (state == IDLE) ? bus.r_mean_i : m_b;

   awb_div #(.QW(QW), .GAIN_W(GAIN_W)) u_div (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (div_start),
      .dividend (div_dvd),
      .divisor  (div_dsr),
      .quotient (div_q),
      .done     (div_done)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         gain_r      <= UNITY;
         gain_b      <= UNITY;
         q_r         <= '0;
         m_g         <= '0;
         m_b         <= '0;
         b_loaded    <= 1'b0;
         gains_valid <= 1'b0;
         busy        <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         gains_valid <= 1'b0;
         if (man) begin
            state    <= IDLE;
            busy     <= 1'b0;
            b_loaded <= 1'b0;
`ifdef AWB_MANUAL_EN
            gain_r   <= bus.manual_gain_r_i;
            gain_b   <= bus.manual_gain_b_i;
`endif
         end else begin
            if (bus.finish_i && state != IDLE)
               overrun <= 1'b1;
            case (state)
               IDLE: if (bus.finish_i) begin
                  state    <= DIV_R;
                  m_g      <= bus.g_mean_i;
                  m_b      <= bus.b_mean_i;
                  busy     <= 1'b1;
                  b_loaded <= 1'b0;
               end
               DIV_R: if (div_done) state <= DIV_B;
               DIV_B: begin
                  if (!b_loaded) begin
                     b_loaded <= 1'b1;
                     q_r      <= div_q;
                  end else if (div_done) begin
                     state <= COMMIT;
                  end
               end
               COMMIT: begin
                  gain_r      <= q_r;
                  gain_b      <= div_q;
                  gains_valid <= 1'b1;
                  busy        <= 1'b0;
                  state       <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign bus.valid_o       = vld_pipe[1];
   assign bus.color_o       = s2.color;
   assign bus.value_o       = s2.value;
   assign bus.last_o        = s2.last;
   assign bus.gain_r_o      = gain_r;
   assign bus.gain_b_o      = gain_b;
   assign bus.gains_valid_o = gains_valid;
   assign bus.busy_o        = busy;
   assign bus.overrun_o     = overrun;

endmodule
